seven_seg_scan_driver: RTL and testbench

Parametrised multiplexed N-digit seven-segment scan driver, successor to the fixed 4-digit hex driver. Adds:
- configurable digit count and scan period
- anti-ghosting blank window
- 16-level brightness PWM
- per-digit enable and blink
- leading-zero suppression and decimal points
- frame-synchronous shadowing of display data, so a value never tears mid-frame

Sits between any value-producing logic and the board's anode/segment pins.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_scan_driver_hex.sv | 15 +
 rtl/seven_seg_scan_driver.sv | 182 ++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
//   HEX_SEG_AL  : 16-entry nibble -> segment table, active-low, bit0 = a .. bit6 = g
//   SEG_OFF_AL  : all-segments-off pattern in active-low form
//   seg_all_off : all-off segment pattern for either segment polarity
package seven_seg_pkg;

  localparam logic [6:0] HEX_SEG_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_OFF_AL = 7'h7F;

  function automatic logic [6:0] seg_all_off(input bit active_low);
    return active_low ? SEG_OFF_AL : ~SEG_OFF_AL;
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_hex.sv
// seg_hex_decoder: combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : 7-bit active-low segment pattern, bit0 = a .. bit6 = g
module seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG_AL[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed N-digit seven-segment scan driver with
// blanking window, 16-level brightness PWM, per-digit enable/blink,
// leading-zero suppression, decimal points and frame-synchronous shadowing.
//   clk, rst     : clock, asynchronous active-high reset
//   num          : hex nibbles, top nibble = leftmost digit (shadowed)
//   dp_in        : decimal point per digit, MSB = leftmost (shadowed)
//   digit_en     : per-digit enable (live)
//   blink_mask   : per-digit blink enable (live)
//   lz_suppress  : leading-zero suppression enable (live)
//   brightness   : 0 = 1/16 on-time .. 15 = full on-time (shadowed)
//   Anode        : registered digit select, MSB = leftmost
//   LED_out      : registered segments, bit0 = a .. bit6 = g
//   dp_out       : registered decimal-point segment
//   frame_done   : one-cycle pulse after the shadow registers load
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned DIGIT_PERIOD     = 262144,
  parameter int unsigned BLANK_CYCLES     = 1024,
  parameter int unsigned BLINK_BITS       = 25,
  parameter int unsigned ANODE_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   num,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_suppress,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     Anode,
  output logic [6:0]                LED_out,
  output logic                      dp_out,
  output logic                      frame_done
);

  localparam int unsigned SLICE = DIGIT_PERIOD / 16;
  localparam int unsigned TW    = $clog2(DIGIT_PERIOD);
  localparam int unsigned SW    = $clog2(NUM_DIGITS);
  localparam int unsigned CW    = (SLICE > 1) ? $clog2(SLICE) : 1;

  localparam bit AN_LOW  = (ANODE_ACTIVE_LOW != 0);
  localparam bit SEG_LOW = (SEG_ACTIVE_LOW != 0);

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    AN_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] SEG_OFF = seg_all_off(SEG_LOW);
  localparam logic       DP_OFF  = SEG_LOW;

  // Scan state
  logic [TW-1:0]         r_timer;
  logic [SW-1:0]         r_slot;
  logic [CW-1:0]         r_slice_cnt;
  logic [3:0]            r_phase;
  logic [BLINK_BITS-1:0] r_blink;

  // Shadowed display data
  logic [4*NUM_DIGITS-1:0] r_num_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [3:0]              r_bright_sh;

  logic w_timer_wrap;
  logic w_load;

  assign w_timer_wrap = (r_timer == TW'(DIGIT_PERIOD - 1));
  assign w_load       = w_timer_wrap && (r_slot == SW'(NUM_DIGITS - 1));

  // Phase is timer / SLICE, tracked by a slice counter that restarts with
  // the timer so the two never drift apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer     <= '0;
      r_slot      <= '0;
      r_slice_cnt <= '0;
      r_phase     <= '0;
      r_blink     <= '0;
    end else begin
      r_blink <= r_blink + BLINK_BITS'(1);
      if (w_timer_wrap) begin
        r_timer     <= '0;
        r_slice_cnt <= '0;
        r_phase     <= '0;
        r_slot      <= (r_slot == SW'(NUM_DIGITS - 1)) ? '0 : r_slot + SW'(1);
      end else begin
        r_timer <= r_timer + TW'(1);
        if (r_slice_cnt == CW'(SLICE - 1)) begin
          r_slice_cnt <= '0;
          r_phase     <= r_phase + 4'd1;
        end else begin
          r_slice_cnt <= r_slice_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_sh    <= '0;
      r_dp_sh     <= '0;
      r_bright_sh <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= w_load;
      if (w_load) begin
        r_num_sh    <= num;
        r_dp_sh     <= dp_in;
        r_bright_sh <= brightness;
      end
    end
  end

  // Visible-digit selection
  logic [SW-1:0]         w_digit;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_en;
  logic                  w_blink_sel;
  logic                  w_lz_sup;
  logic                  w_visible;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [6:0]            w_seg_al;

  // Slot 0 scans the leftmost digit.
  assign w_digit = SW'(NUM_DIGITS - 1) - r_slot;
  assign w_sel   = NUM_DIGITS'(1) << w_digit;

  // Walk digits from the most significant down, tracking whether every
  // nibble so far is zero; digit 0 is exempt from suppression.
  always_comb begin
    logic        zero_run;
    int unsigned d;
    w_nib       = '0;
    w_dp        = 1'b0;
    w_en        = 1'b0;
    w_blink_sel = 1'b0;
    w_lz_sup    = 1'b0;
    zero_run    = 1'b1;
    d           = 0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      d        = NUM_DIGITS - 1 - k;
      zero_run = zero_run && (r_num_sh[4*d +: 4] == 4'h0);
      if (SW'(d) == w_digit) begin
        w_nib       = r_num_sh[4*d +: 4];
        w_dp        = r_dp_sh[d];
        w_en        = digit_en[d];
        w_blink_sel = blink_mask[d];
        w_lz_sup    = lz_suppress && (d != 0) && zero_run;
      end
    end
  end

  assign w_visible = (r_timer >= TW'(BLANK_CYCLES))
                  && (r_phase <= r_bright_sh)
                  && w_en
                  && !(w_blink_sel && r_blink[BLINK_BITS-1])
                  && !w_lz_sup;

  seg_hex_decoder u_dec (
    .nibble (w_nib),
    .seg    (w_seg_al)
  );

  // Anode and segments share one register stage so they switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Anode   <= ANODE_OFF;
      LED_out <= SEG_OFF;
      dp_out  <= DP_OFF;
    end else if (w_visible) begin
      Anode   <= AN_LOW ? ~w_sel : w_sel;
      LED_out <= SEG_LOW ? w_seg_al : ~w_seg_al;
      dp_out  <= SEG_LOW ? ~w_dp : w_dp;
    end else begin
      Anode   <= ANODE_OFF;
      LED_out <= SEG_OFF;
      dp_out  <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver
// (4 digits, 32-cycle slots, 1-cycle blank, 6-bit blink counter, active-low).
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int DP = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   num;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic [3:0]    blink_mask;
  logic          lz_suppress;
  logic [3:0]    brightness;
  logic [3:0]    Anode;
  logic [6:0]    LED_out;
  logic          dp_out;
  logic          frame_done;

  int g;        // posedges since reset release; outputs reflect state g-1
  int n_fd;
  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .NUM_DIGITS       (ND),
    .DIGIT_PERIOD     (DP),
    .BLANK_CYCLES     (1),
    .BLINK_BITS       (6),
    .ANODE_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .num         (num),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .Anode       (Anode),
    .LED_out     (LED_out),
    .dp_out      (dp_out),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    g++;
    if (frame_done === 1'b1) n_fd++;
  endtask

  // Advance until outputs reflect frame f, slot s, timer t.
  task automatic to(input int f, input int s, input int t);
    int target;
    target = f*ND*DP + s*DP + t;
    while (g - 1 < target) tick();
  endtask

  logic [3:0] exp_an  [4];
  logic [6:0] exp_led [4];

  initial begin
    n_checks = 0; n_fail = 0; g = 0; n_fd = 0;
    rst = 1'b1; num = 16'h12AF; dp_in = 4'b0000; digit_en = 4'b1111;
    blink_mask = 4'b0000; lz_suppress = 1'b0; brightness = 4'd15;
    repeat (3) tick();
    chk("rst_anode", Anode, 4'hF);
    chk("rst_led", LED_out, 7'h7F);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_fd", frame_done, 1'b0);
    rst = 1'b0; g = 0; n_fd = 0;

    // Frame 0: reset shadow (zeros, brightness 0)
    to(0,0,0); chk("f0_t0_anode", Anode, 4'hF);
    to(0,0,1); chk("f0_t1_anode", Anode, 4'h7);
    chk("f0_t1_led", LED_out, 7'h40);
    chk("f0_t1_dp", dp_out, 1'b1);
    to(0,0,2); chk("f0_t2_anode", Anode, 4'hF);
    chk("f0_t2_led", LED_out, 7'h7F);
    to(0,3,31); chk("fd_pulse", frame_done, 1'b1);
    to(1,0,0); chk("fd_clear", frame_done, 1'b0);

    // Frame 1: hex scan of 12AF at full brightness
    exp_an  = '{4'h7, 4'hB, 4'hD, 4'hE};
    exp_led = '{7'h79, 7'h24, 7'h08, 7'h0E};
    for (int s = 0; s < 4; s++) begin
      to(1,s,0); chk("scan_blank", Anode, 4'hF);
      to(1,s,5); chk("scan_anode", Anode, exp_an[s]);
      chk("scan_led", LED_out, exp_led[s]);
    end
    num = 16'h1234;
    to(1,3,31); chk("scan_full_t31", Anode, 4'hE);

    // Frames 2-3: shadowing
    to(2,0,5); chk("sh_d3", LED_out, 7'h79);
    to(2,1,5); chk("sh_d2", LED_out, 7'h24);
    to(2,2,3); num = 16'h5678;
    to(2,2,5); chk("sh_d1_old", LED_out, 7'h30);
    chk("sh_d1_anode", Anode, 4'hD);
    to(2,3,5); chk("sh_d0_old", LED_out, 7'h19);
    exp_led = '{7'h12, 7'h02, 7'h78, 7'h00};
    for (int s = 0; s < 4; s++) begin
      to(3,s,5); chk("sh_new", LED_out, exp_led[s]);
    end
    chk("fd_count3", n_fd, 3);
    brightness = 4'd3;

    // Frame 4: brightness 3
    to(4,0,0); chk("br_t0", Anode, 4'hF);
    to(4,0,1); chk("br_t1", Anode, 4'h7);
    to(4,0,7); chk("br_t7", Anode, 4'h7);
    to(4,0,8); chk("br_t8", Anode, 4'hF);
    chk("br_t8_led", LED_out, 7'h7F);
    to(4,1,7); chk("br_s1_t7", Anode, 4'hB);
    to(4,1,8); chk("br_s1_t8", Anode, 4'hF);
    to(4,2,31); chk("br_t31", Anode, 4'hF);
    chk("fd_count4", n_fd, 4);
    brightness = 4'd15; num = 16'h0005; lz_suppress = 1'b1;

    // Frames 5-6: leading-zero suppression
    to(5,0,5); chk("lz_d3", Anode, 4'hF);
    to(5,1,5); chk("lz_d2", Anode, 4'hF);
    to(5,2,5); chk("lz_d1", Anode, 4'hF);
    to(5,3,5); chk("lz_d0_anode", Anode, 4'hE);
    chk("lz_d0_led", LED_out, 7'h12);
    num = 16'h0000;
    to(6,2,5); chk("lz0_d1", Anode, 4'hF);
    to(6,3,5); chk("lz0_d0_anode", Anode, 4'hE);
    chk("lz0_d0_led", LED_out, 7'h40);
    to(6,3,6);
    num = 16'h8888; dp_in = 4'b0100; digit_en = 4'b1110;
    blink_mask = 4'b1000; lz_suppress = 1'b0;

    // Frame 7: blink (phase 0 in slot 0), enable, dp
    to(7,0,5); chk("bl_d3_anode", Anode, 4'h7);
    chk("bl_d3_dp", dp_out, 1'b1);
    to(7,1,5); chk("dp_d2_anode", Anode, 4'hB);
    chk("dp_d2_dp", dp_out, 1'b0);
    to(7,2,5); chk("dp_d1_dp", dp_out, 1'b1);
    to(7,3,5); chk("en_d0_anode", Anode, 4'hF);
    chk("en_d0_led", LED_out, 7'h7F);
    to(7,3,6); blink_mask = 4'b0100;

    // Frame 8: blink phase 1 during slot 1 blanks digit 2
    to(8,0,5); chk("bl2_d3", Anode, 4'h7);
    to(8,1,5); chk("bl2_d2_anode", Anode, 4'hF);
    chk("bl2_d2_dp", dp_out, 1'b1);

    // Reset mid-slot
    to(8,2,17); chk("pre_rst_anode", Anode, 4'hD);
    rst = 1'b1;
    #1;
    chk("mid_rst_anode", Anode, 4'hF);
    chk("mid_rst_led", LED_out, 7'h7F);
    chk("mid_rst_dp", dp_out, 1'b1);
    chk("mid_rst_fd", frame_done, 1'b0);
    repeat (2) tick();
    rst = 1'b0; g = 0;
    to(0,0,0); chk("post_rst_t0", Anode, 4'hF);
    to(0,0,1); chk("post_rst_anode", Anode, 4'h7);
    chk("post_rst_led", LED_out, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
